// File: rtl/serial_divisibility_by_n_fsm_pkg.sv
// Shared types and helpers for the serial divisibility tester.
// The optional LSB-first ordering is enabled with SERIAL_DIV_LSB_FIRST_EN.
package serial_div_pkg;

    typedef enum logic {
        ORDER_MSB = 1'b0,
        ORDER_LSB = 1'b1
    } bit_order_e;

    localparam int MAX_DIVISOR = 255;

    // (2r + b) mod n for r < n: the doubled value is below 2n, so one subtract suffices.
    function automatic logic [7:0] mod_double(input logic [7:0] r, input logic b,
                                              input logic [8:0] n);
        logic [8:0] t;
        t = {r, b};
        if (t >= n) begin
            t = t - n;
        end
        return t[7:0];
    endfunction

endpackage

// File: rtl/serial_divisibility_by_n_fsm_if.sv
// Bit-stream and result bundle of the serial divisibility tester.
// Carries lsb_first only when SERIAL_DIV_LSB_FIRST_EN is defined.
interface serial_divisibility_by_n_fsm_if #(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 16
);
    localparam int REM_W = $clog2(DIVISOR);

    logic             bit_valid;
    logic             new_bit;
    logic             frame_start;
`ifdef SERIAL_DIV_LSB_FIRST_EN
    logic             lsb_first;
`endif
    logic [REM_W-1:0] remainder;
    logic             div_by_n;
    logic [CNT_W-1:0] bit_count;

`ifdef SERIAL_DIV_LSB_FIRST_EN
    modport master (output bit_valid, output new_bit, output frame_start, output lsb_first,
                    input remainder, input div_by_n, input bit_count);
    modport slave  (input bit_valid, input new_bit, input frame_start, input lsb_first,
                    output remainder, output div_by_n, output bit_count);
`else
    modport master (output bit_valid, output new_bit, output frame_start,
                    input remainder, input div_by_n, input bit_count);
    modport slave  (input bit_valid, input new_bit, input frame_start,
                    output remainder, output div_by_n, output bit_count);
`endif

endinterface

// File: rtl/serial_divisibility_by_n_fsm_mod_step.sv
// Modular addition (r + addend) mod DIVISOR for operands already below DIVISOR.
module serial_mod_step
    import serial_div_pkg::*;
#(
    parameter int DIVISOR = 5
) (
    input  logic [$clog2(DIVISOR)-1:0] r,
    input  logic [$clog2(DIVISOR)-1:0] addend,
    output logic [$clog2(DIVISOR)-1:0] sum
);
    localparam int               REM_W = $clog2(DIVISOR);
    localparam logic [REM_W:0]   N_W   = (REM_W + 1)'(DIVISOR);

    logic [REM_W:0] raw;

    // Both operands are below N, so the raw sum is below 2N and one subtract reduces it.
    always_comb begin
        raw = {1'b0, r} + {1'b0, addend};
        if (raw >= N_W) begin
            sum = REM_W'(raw - N_W);
        end else begin
            sum = REM_W'(raw);
        end
    end

endmodule

// File: rtl/serial_divisibility_by_n_fsm.sv
// Serial mod-N tester: one bit per accepted cycle, running remainder, div flag, bit counter.
// Define SERIAL_DIV_LSB_FIRST_EN to add per-frame LSB-first ordering and the weight register.
module serial_divisibility_by_n_fsm
    import serial_div_pkg::*;
#(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    serial_divisibility_by_n_fsm_if.slave  bus
);
    localparam int             REM_W = $clog2(DIVISOR);
    localparam logic [REM_W:0] N_W   = (REM_W + 1)'(DIVISOR);
    localparam logic [8:0]     N_9   = 9'(DIVISOR);

    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [REM_W-1:0] base_r;
    logic [CNT_W-1:0] base_cnt;
    logic [REM_W-1:0] dbl_r;
    logic [REM_W-1:0] msb_next;

    // A frame_start restarts from the empty number even when a bit arrives in the same cycle.
    assign base_r   = bus.frame_start ? '0 : rem_q;
    assign base_cnt = bus.frame_start ? '0 : cnt_q;
    assign dbl_r    = REM_W'(mod_double(8'(base_r), 1'b0, N_9));

    serial_mod_step #(.DIVISOR(DIVISOR)) u_msb_step (
        .r      (dbl_r),
        .addend (REM_W'(bus.new_bit)),
        .sum    (msb_next)
    );

`ifdef SERIAL_DIV_LSB_FIRST_EN
    localparam logic [REM_W-1:0] W_ONE = REM_W'(1);

    logic [REM_W-1:0] w_q, w_d;
    bit_order_e       order_q, order_d;
    logic [REM_W-1:0] base_w;
    logic [REM_W-1:0] lsb_add;
    logic [REM_W-1:0] lsb_next;
    logic [REM_W-1:0] w_next;

    assign base_w  = bus.frame_start ? W_ONE : w_q;
    assign lsb_add = bus.new_bit ? base_w : '0;
    assign w_next  = REM_W'(mod_double(8'(base_w), 1'b0, N_9));

    serial_mod_step #(.DIVISOR(DIVISOR)) u_lsb_step (
        .r      (base_r),
        .addend (lsb_add),
        .sum    (lsb_next)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b1;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            w_q     <= W_ONE;
            order_q <= ORDER_MSB;
`endif
        end else begin
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            w_q     <= w_d;
            order_q <= order_d;
`endif
        end
    end

    always_comb begin
        rem_d = rem_q;
        cnt_d = cnt_q;
`ifdef SERIAL_DIV_LSB_FIRST_EN
        w_d     = w_q;
        order_d = order_q;
        if (bus.frame_start) begin
            order_d = bus.lsb_first ? ORDER_LSB : ORDER_MSB;
        end
`endif
        if (bus.frame_start) begin
            rem_d = '0;
            cnt_d = '0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            w_d   = W_ONE;
`endif
        end
        if (bus.bit_valid) begin
`ifdef SERIAL_DIV_LSB_FIRST_EN
            rem_d = (order_d == ORDER_LSB) ? lsb_next : msb_next;
            w_d   = w_next;
`else
            rem_d = msb_next;
`endif
            cnt_d = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
        end
        div_d = (rem_d == '0);
    end

    assign bus.remainder = rem_q;
    assign bus.div_by_n  = div_q;
    assign bus.bit_count = cnt_q;

    a_divisor_range : assert property (@(posedge clk)
        (DIVISOR >= 2) && (DIVISOR <= MAX_DIVISOR));

    a_rem_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, rem_q} < N_W));

endmodule
